// File: rtl/platform_spawner_if.sv
// Platform hand-off channel: registered head x plus valid/ready.
// master = spawner side, slave = game/platform consumer side.
interface platform_spawner_if;
  logic [9:0] plat_x;
  logic       plat_valid;
  logic       plat_ready;

  modport master (
    output plat_x,
    output plat_valid,
    input  plat_ready
  );

  modport slave (
    input  plat_x,
    input  plat_valid,
    output plat_ready
  );
endinterface

// File: rtl/platform_spawner.sv
// Filters LFSR samples into platform x positions and queues them.
// Optional PLAT_STATS_EN adds a saturating reject_total counter.
module platform_spawner #(
  parameter int X_MIN      = 20,
  parameter int X_RANGE    = 440,
  parameter int MIN_GAP    = 64,
  parameter int MAX_REJECT = 7,
  parameter int DEPTH      = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [8:0]  rnd,
  input  logic        rnd_valid,
  input  logic        flush,
  platform_spawner_if.master plat,
  output logic [2:0]  fifo_count
`ifdef PLAT_STATS_EN
  ,
  output logic [15:0] reject_total
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(MAX_REJECT + 1);
  localparam logic [9:0] X_MID = 10'(X_MIN + X_RANGE / 2);
  localparam logic [9:0] X_TOP = 10'(X_MIN + X_RANGE - 1);

  typedef enum logic {S_WAIT, S_CHECK} state_t;

  state_t      r_state, w_state_n;
  logic [8:0]  r_cand;
  logic [9:0]  r_last_x;
  logic [RW-1:0] r_rej;
  logic [9:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [2:0]  r_count;

  logic [9:0]  w_x, w_diff, w_fx_hi, w_fx, w_push_x;
  logic        w_in_range, w_ok, w_force;
  logic        w_full, w_pop, w_room, w_push, w_rej_evt;

  assign w_x        = {1'b0, r_cand} + 10'(X_MIN);
  assign w_in_range = {1'b0, r_cand} < 10'(X_RANGE);
  assign w_diff     = (w_x >= r_last_x) ? w_x - r_last_x
                                        : r_last_x - w_x;
  assign w_ok       = w_in_range && (w_diff >= 10'(MIN_GAP));
  assign w_force    = !w_ok && (r_rej == RW'(MAX_REJECT));
  assign w_fx_hi    = r_last_x + 10'(MIN_GAP);
  assign w_fx       = (w_fx_hi <= X_TOP) ? w_fx_hi
                                         : r_last_x - 10'(MIN_GAP);

  assign w_full = (r_count == 3'(DEPTH));
  assign w_pop  = plat.plat_valid && plat.plat_ready;
  assign w_room = !w_full || w_pop;

  assign plat.plat_x     = r_mem[r_rd];
  assign plat.plat_valid = (r_count != 3'd0);
  assign fifo_count      = r_count;

  // Next state, push decision and reject event for the candidate
  always_comb begin
    w_state_n = r_state;
    w_push    = 1'b0;
    w_push_x  = w_x;
    w_rej_evt = 1'b0;
    unique case (r_state)
      S_WAIT: begin
        if (rnd_valid) w_state_n = S_CHECK;
      end
      S_CHECK: begin
        if (w_ok || w_force) begin
          if (w_room) begin
            w_push    = 1'b1;
            w_push_x  = w_ok ? w_x : w_fx;
            w_state_n = S_WAIT;
          end
        end else begin
          w_state_n = S_WAIT;
        end
        w_rej_evt = !w_ok && (!w_force || w_room);
      end
      default: w_state_n = S_WAIT;
    endcase
  end

  // FSM state, candidate capture, last x and reject run length
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= S_WAIT;
      r_cand   <= '0;
      r_last_x <= X_MID;
      r_rej    <= '0;
    end else if (flush) begin
      r_state <= S_WAIT;
      r_rej   <= '0;
    end else begin
      r_state <= w_state_n;
      if (r_state == S_WAIT && rnd_valid) r_cand <= rnd;
      if (w_push) begin
        r_last_x <= w_push_x;
        r_rej    <= '0;
      end else if (r_state == S_CHECK && !w_ok && !w_force) begin
        r_rej <= r_rej + 1'b1;
      end
    end
  end

  // Platform FIFO: flush beats push/pop, pop gated by non-empty
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_push_x;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + 3'(w_push) - 3'(w_pop);
    end
  end

`ifdef PLAT_STATS_EN
  logic [15:0] r_rej_total;
  assign reject_total = r_rej_total;

  // Saturating count of rejected samples, survives flush
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_rej_total <= '0;
    else if (w_rej_evt && r_rej_total != 16'hFFFF)
      r_rej_total <= r_rej_total + 16'd1;
  end
`else
  logic w_unused;
  assign w_unused = w_rej_evt;
`endif

endmodule

// File: tb/tb_platform_spawner.sv
// Directed bench for platform_spawner with an expected-x scoreboard.
// Define PLAT_STATS_EN to also check reject_total.
module tb_platform_spawner;
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [8:0] rnd = '0;
  logic       rnd_valid = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] fifo_count;
`ifdef PLAT_STATS_EN
  logic [15:0] reject_total;
`endif

  platform_spawner_if pif ();

  platform_spawner dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .rnd        (rnd),
    .rnd_valid  (rnd_valid),
    .flush      (flush),
    .plat       (pif.master),
    .fifo_count (fifo_count)
`ifdef PLAT_STATS_EN
    ,
    .reject_total (reject_total)
`endif
  );

  always #10 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] q[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic sample(input logic [8:0] v);
    rnd = v;
    rnd_valid = 1'b1;
    tick();
    rnd_valid = 1'b0;
    tick();
  endtask

  task automatic drain(input string tag);
    pif.plat_ready = 1'b1;
    for (int i = 0; i < 10 && pif.plat_valid; i++) begin
      if (q.size() == 0) chk({tag, "_extra"}, 1, 0);
      else chk({tag, "_x"}, pif.plat_x, q.pop_front());
      tick();
    end
    pif.plat_ready = 1'b0;
    chk({tag, "_left"}, q.size(), 0);
    chk({tag, "_cnt"}, fifo_count, 0);
  endtask

  initial begin
    pif.plat_ready = 1'b0;
    #25;
    Reset_n = 1'b1;
    tick();
    chk("rst_valid", pif.plat_valid, 0);
    chk("rst_x", pif.plat_x, 0);
    chk("rst_cnt", fifo_count, 0);

    // basic accept and latency
    rnd = 9'd100;
    rnd_valid = 1'b1;
    tick();
    rnd_valid = 1'b0;
    chk("lat_early", pif.plat_valid, 0);
    tick();
    q.push_back(10'd120);
    chk("lat_valid", pif.plat_valid, 1);
    chk("lat_x", pif.plat_x, 120);
    chk("lat_cnt", fifo_count, 1);

    // range and gap rejects, then accept
    sample(9'd470);
    chk("rej_range", fifo_count, 1);
    sample(9'd130);
    chk("rej_gap", fifo_count, 1);
    sample(9'd300);
    q.push_back(10'd320);
    chk("acc_cnt", fifo_count, 2);
    chk("acc_head", pif.plat_x, 120);

    // async reset mid-stream
    rnd = 9'd0;
    rnd_valid = 1'b1;
    tick();
    rnd_valid = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk("arst_valid", pif.plat_valid, 0);
    chk("arst_cnt", fifo_count, 0);
    q.delete();
    tick();
    Reset_n = 1'b1;
    tick();
    chk("arst_hold", fifo_count, 0);

    // forced placement after eight rejects
    sample(9'd100);
    q.push_back(10'd120);
    for (int i = 0; i < 7; i++) sample(9'd470);
    chk("force_pre", fifo_count, 1);
    sample(9'd470);
    q.push_back(10'd184);
    chk("force_cnt", fifo_count, 2);
`ifdef PLAT_STATS_EN
    chk("stats_rej", reject_total, 8);
`endif
    drain("force");

    // full FIFO hold and push+pop when full
    Reset_n = 1'b0;
    #1;
    q.delete();
    tick();
    Reset_n = 1'b1;
    tick();
    sample(9'd0);   q.push_back(10'd20);
    sample(9'd100); q.push_back(10'd120);
    sample(9'd200); q.push_back(10'd220);
    sample(9'd300); q.push_back(10'd320);
    sample(9'd400); q.push_back(10'd420);
    chk("full_cnt", fifo_count, 4);
    tick();
    chk("full_hold", fifo_count, 4);
    pif.plat_ready = 1'b1;
    chk("full_pop_x", pif.plat_x, q.pop_front());
    tick();
    pif.plat_ready = 1'b0;
    chk("full_pp_cnt", fifo_count, 4);
    chk("full_pp_head", pif.plat_x, 120);
    drain("full");

    // flush with simultaneous push and pop
    sample(9'd0);   q.push_back(10'd20);
    sample(9'd100); q.push_back(10'd120);
    sample(9'd200); q.push_back(10'd220);
    chk("fl_pre", fifo_count, 3);
    rnd = 9'd300;
    rnd_valid = 1'b1;
    tick();
    rnd_valid = 1'b0;
    flush = 1'b1;
    pif.plat_ready = 1'b1;
    tick();
    flush = 1'b0;
    pif.plat_ready = 1'b0;
    q.delete();
    chk("fl_cnt", fifo_count, 0);
    chk("fl_valid", pif.plat_valid, 0);
    sample(9'd400);
    q.push_back(10'd420);
    chk("fl_after", fifo_count, 1);
`ifdef PLAT_STATS_EN
    chk("stats_keep", reject_total, 0);
`endif
    drain("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
